requant_relu: RTL and testbench

Post-layer activation stage that sits directly downstream of the fully connected layer. It consumes the layer's signed BIAS_WIDTH accumulator vector after that layer's `done`. It requantizes each element with a run-time multiplier and shift, applies ReLU (optional), saturates to signed WEIGHTS_WIDTH, and stores the result in an output register vector. That vector feeds the next layer's `inputs`. Elements are processed one per cycle through a 3-stage pipeline under a start/done handshake.

---
 rtl/nn_pkg.sv | 27 ++
 rtl/requant_lane.sv | 86 ++++++++
 rtl/requant_relu.sv | 129 ++++++++++++
 tb/tb_requant_relu.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared requant types and constants; REQUANT_RELU_EN selects ReLU clamping
package nn_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} requant_state_t;

`ifdef REQUANT_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  // Largest positive activation for a signed output of width ww.
  function automatic int act_max(input int ww);
    return (1 << (ww - 1)) - 1;
  endfunction

  // Lowest activation: zero with ReLU, otherwise the most negative signed value.
  function automatic int act_min(input int ww);
    return RELU_EN ? 0 : -(1 << (ww - 1));
  endfunction

  // Signed accumulator times zero-extended unsigned multiplier.
  function automatic int prod_width(input int bw, input int mw);
    return bw + mw + 1;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - three-stage multiply / round-shift / clamp datapath for one element
module requant_lane
  import nn_pkg::*;
#(
  parameter int BIAS_WIDTH    = 32,
  parameter int WEIGHTS_WIDTH = 8,
  parameter int MULT_WIDTH    = 16,
  parameter int IDX_W         = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [IDX_W-1:0]         in_idx,
  input  logic [BIAS_WIDTH-1:0]    elem,
  input  logic [MULT_WIDTH-1:0]    mult,
  input  logic [4:0]               shift,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         out_idx,
  output logic [WEIGHTS_WIDTH-1:0] act,
  output logic                     active
);

  localparam int PW     = prod_width(BIAS_WIDTH, MULT_WIDTH);
  localparam int ACT_HI = act_max(WEIGHTS_WIDTH);
  localparam int ACT_LO = act_min(WEIGHTS_WIDTH);

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] m_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] half;
  logic signed [PW-1:0] rounded;
  logic signed [PW-1:0] prod_q;
  logic signed [PW-1:0] s2_q;
  logic                 v1;
  logic                 v2;
  logic [IDX_W-1:0]     idx1;
  logic [IDX_W-1:0]     idx2;

  // Widen both operands to the full product width; the true product always fits.
  assign a_ext = PW'($signed(elem));
  assign m_ext = PW'($signed({1'b0, mult}));
  assign prod  = a_ext * m_ext;

  // Rounding bias of half an LSB of the shifted result; none when no shift is applied.
  always_comb begin
    half = '0;
    if (shift != 5'd0) begin
      half = PW'(1) << (shift - 5'd1);
    end
    rounded = (prod_q + half) >>> shift;
  end

  // Pipeline registers for S1 (product) and S2 (rounded value), with valid and index riding along.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      idx1   <= '0;
      idx2   <= '0;
      prod_q <= '0;
      s2_q   <= '0;
    end else begin
      v1     <= in_valid;
      idx1   <= in_idx;
      prod_q <= prod;
      v2     <= v1;
      idx2   <= idx1;
      s2_q   <= rounded;
    end
  end

  // S3 saturation to the activation range; the top registers the result into act_out.
  always_comb begin
    act = s2_q[WEIGHTS_WIDTH-1:0];
    if (s2_q > PW'(ACT_HI)) begin
      act = WEIGHTS_WIDTH'(ACT_HI);
    end else if (s2_q < PW'(ACT_LO)) begin
      act = WEIGHTS_WIDTH'(ACT_LO);
    end
  end

  assign out_valid = v2;
  assign out_idx   = idx2;
  assign active    = v1 | v2;

endmodule

// File: rtl/requant_relu.sv
// rtl/requant_relu.sv - requantize + saturate (ReLU when REQUANT_RELU_EN) a layer's accumulator vector
module requant_relu
  import nn_pkg::*;
#(
  parameter int VEC_SIZE      = 512,
  parameter int BIAS_WIDTH    = 32,
  parameter int WEIGHTS_WIDTH = 8,
  parameter int MULT_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [MULT_WIDTH-1:0]             scale_mult,
  input  logic [4:0]                        scale_shift,
  input  logic [VEC_SIZE*BIAS_WIDTH-1:0]    layer_in,
  output logic                              busy,
  output logic                              done,
  output logic [VEC_SIZE*WEIGHTS_WIDTH-1:0] act_out
);

  localparam int IDX_W = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;

  requant_state_t           state;
  requant_state_t           next_state;
  logic [IDX_W-1:0]         cnt;
  logic                     last_issue;
  logic [MULT_WIDTH-1:0]    mult_q;
  logic [4:0]               shift_q;
  logic [BIAS_WIDTH-1:0]    elem;
  logic                     issue_valid;
  logic                     wr_valid;
  logic [IDX_W-1:0]         wr_idx;
  logic [WEIGHTS_WIDTH-1:0] wr_act;
  logic                     pipe_active;

  assign last_issue  = (cnt == IDX_W'(VEC_SIZE - 1));
  assign issue_valid = (state == RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and status outputs; done is a single cycle spent in DONE.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) next_state = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_issue) next_state = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!pipe_active) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Issue counter walks 0..VEC_SIZE-1 while running and rewinds for the next pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == RUN) begin
      cnt <= last_issue ? '0 : cnt + 1'b1;
    end
  end

  // Scale factors are captured only when a pass is accepted, so later changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_q  <= '0;
      shift_q <= '0;
    end else if (state == IDLE && start) begin
      mult_q  <= scale_mult;
      shift_q <= scale_shift;
    end
  end

  // Select the accumulator addressed by the issue counter.
  always_comb begin
    elem = '0;
    for (int i = 0; i < VEC_SIZE; i++) begin
      if (cnt == IDX_W'(i)) elem = layer_in[i*BIAS_WIDTH +: BIAS_WIDTH];
    end
  end

  requant_lane #(
    .BIAS_WIDTH    (BIAS_WIDTH),
    .WEIGHTS_WIDTH (WEIGHTS_WIDTH),
    .MULT_WIDTH    (MULT_WIDTH),
    .IDX_W         (IDX_W)
  ) u_lane (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_valid),
    .in_idx    (cnt),
    .elem      (elem),
    .mult      (mult_q),
    .shift     (shift_q),
    .out_valid (wr_valid),
    .out_idx   (wr_idx),
    .act       (wr_act),
    .active    (pipe_active)
  );

  // Output vector: each element holds its last value until the pipeline overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_out <= '0;
    end else if (wr_valid) begin
      for (int i = 0; i < VEC_SIZE; i++) begin
        if (wr_idx == IDX_W'(i)) act_out[i*WEIGHTS_WIDTH +: WEIGHTS_WIDTH] <= wr_act;
      end
    end
  end

endmodule

// File: tb/tb_requant_relu.sv
// tb/tb_requant_relu.sv - directed and randomized bench for requant_relu against an arithmetic model
module tb_requant_relu;

  localparam int N  = 4;
  localparam int BW = 32;
  localparam int WW = 8;
  localparam int MW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [MW-1:0]   scale_mult = '0;
  logic [4:0]      scale_shift = '0;
  logic [N*BW-1:0] layer_in = '0;
  logic            busy;
  logic            done;
  logic [N*WW-1:0] act_out;

  int vectors = 0;
  int miscompares = 0;
  int vin[N];

  requant_relu #(
    .VEC_SIZE      (N),
    .BIAS_WIDTH    (BW),
    .WEIGHTS_WIDTH (WW),
    .MULT_WIDTH    (MW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .scale_mult  (scale_mult),
    .scale_shift (scale_shift),
    .layer_in    (layer_in),
    .busy        (busy),
    .done        (done),
    .act_out     (act_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Real-number view: scale, divide by 2^sh rounding halves upward, then clip.
  function automatic longint model(input longint a, input longint m, input int sh);
    longint p;
    longint lo;
    longint hi;
    p = a * m;
    if (sh > 0) p = (p + (longint'(1) << (sh - 1))) >>> sh;
    hi = (longint'(1) << (WW - 1)) - 1;
`ifdef REQUANT_RELU_EN
    lo = 0;
`else
    lo = -(longint'(1) << (WW - 1));
`endif
    if (p > hi) p = hi;
    if (p < lo) p = lo;
    return p;
  endfunction

  task automatic run_pass(input int m, input int sh, input bit poke, input string tag);
    longint exp_v[N];
    int     k;
    bit     busy_gap;
    for (int i = 0; i < N; i++) exp_v[i] = model(longint'(vin[i]), longint'(m), sh);
    @(negedge clk);
    for (int i = 0; i < N; i++) layer_in[i*BW +: BW] = vin[i];
    scale_mult  = m[MW-1:0];
    scale_shift = sh[4:0];
    start       = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    k        = 0;
    busy_gap = 1'b0;
    while (!done && k < 20) begin
      if (!busy) busy_gap = 1'b1;
      if (poke && k == 2) begin
        start      = 1'b1;
        scale_mult = 16'd100;
      end
      if (poke && k == 3) start = 1'b0;
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, longint'(k), longint'(N + 3));
    check({tag, " busy_held"}, longint'(busy_gap), 0);
    check({tag, " busy_in_done"}, longint'(busy), 0);
    @(negedge clk);
    check({tag, " done_width"}, longint'(done), 0);
    for (int i = 0; i < N; i++)
      check($sformatf("%s act[%0d]", tag, i), longint'($signed(act_out[i*WW +: WW])), exp_v[i]);
  endtask

  initial begin
    bit saw_done;
    int m;
    int sh;

    repeat (2) @(negedge clk);
    check("reset act_out", longint'(act_out), 0);
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    rst = 1'b0;

    vin = '{5, -3, 200, -200};
    run_pass(1, 0, 1'b0, "saturation");

    vin = '{1, 2, -2, -1};
    run_pass(3, 2, 1'b0, "rounding");

    vin = '{1, 2, -2, -1};
    run_pass(3, 2, 1'b1, "ignored_inputs");

    vin = '{1, -1, 0, 2147483647};
    run_pass(65535, 0, 1'b0, "large_mult");

    // Abort a pass with reset three cycles after it starts.
    @(negedge clk);
    vin = '{50, 60, 70, 80};
    for (int i = 0; i < N; i++) layer_in[i*BW +: BW] = vin[i];
    scale_mult  = 16'd1;
    scale_shift = 5'd0;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst act_out", longint'(act_out), 0);
    check("midrst busy", longint'(busy), 0);
    check("midrst done", longint'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midrst no_done", longint'(saw_done), 0);
    run_pass(1, 0, 1'b0, "after_reset");

    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < N; i++) begin
        if (p[0]) vin[i] = int'($urandom);
        else      vin[i] = int'($urandom_range(0, 600)) - 300;
      end
      if (p[1]) begin
        m  = int'($urandom_range(0, 65535));
        sh = int'($urandom_range(0, 31));
      end else begin
        m  = int'($urandom_range(0, 8));
        sh = int'($urandom_range(0, 4));
      end
      run_pass(m, sh, 1'b0, $sformatf("random%0d", p));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
